// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronise and de-glitch ps2c/ps2d, deframe 11-bit frames.
// Optional macro PS2_PARITY_CHECK_EN adds odd-parity checking in LOAD.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       frame_err,
    output logic       busy
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DPS,
        LOAD
    } state_t;

    state_t                  state_q, state_d;
    logic                    ps2c_meta_q, ps2c_sync_q;
    logic                    ps2d_meta_q, ps2d_sync_q;
    logic [FILTER_LEN-1:0]   filter_q, filter_d;
    logic                    fclk_q, fclk_d;
    logic                    fall;
    logic [3:0]              n_q, n_d;
    logic [9:0]              b_q, b_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [7:0]              dout_q, dout_d;
    logic                    frame_ok;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false fall after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2c_meta_q <= 1'b1;
            ps2c_sync_q <= 1'b1;
            ps2d_meta_q <= 1'b1;
            ps2d_sync_q <= 1'b1;
        end else begin
            ps2c_meta_q <= ps2c;
            ps2c_sync_q <= ps2c_meta_q;
            ps2d_meta_q <= ps2d;
            ps2d_sync_q <= ps2d_meta_q;
        end
    end

    always_comb begin
        filter_d = {ps2c_sync_q, filter_q[FILTER_LEN-1:1]};
        fclk_d   = fclk_q;
        if (&filter_q) begin
            fclk_d = 1'b1;
        end else if (~|filter_q) begin
            fclk_d = 1'b0;
        end
        fall = fclk_q & ~fclk_d;
    end

    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        frame_ok = b_q[9] & (^b_q[8:0]);
`else
        // Parity bit is received but deliberately ignored in this build.
        frame_ok = b_q[9] | (1'b0 & b_q[8]);
`endif
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        b_d          = b_q;
        timer_d      = timer_q;
        dout_d       = dout_q;
        dout         = dout_q;
        rx_done_tick = 1'b0;
        frame_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall && rx_en && !ps2d_sync_q) begin
                    state_d = DPS;
                    n_d     = 4'd9;
                    timer_d = '0;
                end
            end
            DPS: begin
                if (fall) begin
                    b_d     = {ps2d_sync_q, b_q[9:1]};
                    timer_d = '0;
                    if (n_q == 4'd0) begin
                        state_d = LOAD;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            LOAD: begin
                state_d = IDLE;
                // dout is bypassed so the new byte is visible in the same cycle as the tick.
                if (frame_ok) begin
                    dout_d       = b_q[7:0];
                    dout         = b_q[7:0];
                    rx_done_tick = 1'b1;
                end else begin
                    frame_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            filter_q <= '1;
            fclk_q   <= 1'b1;
            n_q      <= '0;
            b_q      <= '0;
            timer_q  <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            filter_q <= filter_d;
            fclk_q   <= fclk_d;
            n_q      <= n_d;
            b_q      <= b_d;
            timer_q  <= timer_d;
            dout_q   <= dout_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: expected ticks/errors queued at stimulus time, popped on DUT output.
module tb_ps2_frame_rx;

    localparam int F = 8;
    localparam int T = 500;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_en;
    logic       ps2d;
    logic       ps2c;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       busy;

    ps2_frame_rx #(
        .FILTER_LEN    (F),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_en       (rx_en),
        .ps2d        (ps2d),
        .ps2c        (ps2c),
        .rx_done_tick(rx_done_tick),
        .dout        (dout),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] data;
        longint     at;
    } exp_t;

    exp_t       sb[$];
    exp_t       e_mon;
    logic [7:0] last_good;
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (rx_done_tick || frame_err)) begin
            check("tick_err_exclusive", {63'd0, rx_done_tick & frame_err}, 64'd0);
            if (sb.size() == 0) begin
                check("spurious_event", {62'd0, rx_done_tick, frame_err}, 64'd0);
            end else begin
                e_mon = sb.pop_front();
                check("event_kind", {63'd0, frame_err}, {63'd0, e_mon.err});
                check("event_cycle", cyc, e_mon.at);
                if (!e_mon.err) begin
                    check("dout", {56'd0, dout}, {56'd0, e_mon.data});
                    last_good = e_mon.data;
                end else begin
                    check("dout_hold", {56'd0, dout}, {56'd0, last_good});
                end
            end
        end
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit par_flip, input bit stop_v);
        return {stop_v, (~^d) ^ par_flip, d, 1'b0};
    endfunction

    // One PS/2 bit per 80 clk: data set up, 40 clk low, clock high again.
    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_v, input bit drop_en);
        logic [10:0] fr;
        exp_t        e;
        fr = make_frame(d, par_flip, stop_v);
        for (int i = 0; i < 11; i++) begin
            ps2d = fr[i];
            repeat (10) @(negedge clk);
            ps2c = 1'b0;
            if (i == 10) begin
                e.err  = !stop_v || (PAR_CHK && par_flip);
                e.data = d;
                e.at   = cyc + F + 3;
                sb.push_back(e);
            end
            repeat (40) @(negedge clk);
            ps2c = 1'b1;
            if (i == 0 && drop_en) rx_en = 1'b0;
            repeat (30) @(negedge clk);
        end
        ps2d  = 1'b1;
        rx_en = 1'b1;
    endtask

    task automatic send_partial(input int nbits, input bit exp_timeout);
        logic [10:0] fr;
        longint      last_fall;
        exp_t        e;
        fr = make_frame(8'h29, 1'b0, 1'b1);
        last_fall = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2d = fr[i];
            repeat (10) @(negedge clk);
            ps2c = 1'b0;
            last_fall = cyc;
            repeat (40) @(negedge clk);
            ps2c = 1'b1;
            repeat (30) @(negedge clk);
        end
        ps2d = 1'b1;
        if (exp_timeout) begin
            e.err  = 1'b1;
            e.data = 8'h00;
            e.at   = last_fall + F + T + 2;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && sb.size() != 0; k++) @(negedge clk);
        check("drain", sb.size(), 64'd0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        rx_en     = 1'b1;
        ps2d      = 1'b1;
        ps2c      = 1'b1;
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        check("reset_tick", {63'd0, rx_done_tick}, 64'd0);
        check("reset_err", {63'd0, frame_err}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_dout", {56'd0, dout}, 64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        drain();

        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        check("busy_gap", {63'd0, busy}, 64'd0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        drain();

        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        drain();

        send_frame(8'h3A, 1'b1, 1'b1, 1'b0);
        drain();

        send_partial(5, 1'b1);
        drain();
        send_frame(8'h29, 1'b0, 1'b1, 1'b1);
        drain();

        ps2d = 1'b0;
        for (int g = 0; g < 5; g++) begin
            ps2c = 1'b0;
            repeat (3) @(negedge clk);
            ps2c = 1'b1;
            repeat (20) @(negedge clk);
            check("glitch_busy", {63'd0, busy}, 64'd0);
        end
        ps2d = 1'b1;
        repeat (20) @(negedge clk);

        send_partial(4, 1'b0);
        check("midframe_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_dout", {56'd0, dout}, 64'd0);
        check("rst_mid_tick", {63'd0, rx_done_tick}, 64'd0);
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (T + 50) @(negedge clk);
        check("post_reset_dout", {56'd0, dout}, 64'd0);

        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
